// File: rtl/n_way_job_pkg.sv
// Shared types for the n-way job controller.
//   job_state_e  : per-job state, 3-bit, FINISHED=0 RUNNING=1 WAITING=2
//                  SUSPENDED=3 KILLED=4
//   ctrl_state_e : controller FSM state
//   JOB_STATE_W  : width of one job state field
package n_way_job_pkg;

    localparam int JOB_STATE_W = 3;

    typedef enum logic [JOB_STATE_W-1:0] {
        FINISHED  = 3'd0,
        RUNNING   = 3'd1,
        WAITING   = 3'd2,
        SUSPENDED = 3'd3,
        KILLED    = 3'd4
    } job_state_e;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ALL,
        AWAIT,
        KILL,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/n_way_job_slot.sv
// One job slot: holds the state of a single job and applies its transitions.
// Optional feature macro: N_WAY_JOB_CTRL_SUSPEND_EN (suspend/resume support).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   active          : controller is not in IDLE (inputs are ignored in IDLE)
//   launch          : LAUNCH cycle, forces the slot to WAITING
//   kill_phase      : KILL cycle, kills the job unless it is finishing now
//   started, done   : job handshake pulses
//   suspend, resume : (macro only) suspend/resume requests
//   state           : registered job state
//   waiting_nxt     : next state is WAITING (lets WAIT_ALL exit early)
//   kill            : kill pulse for this job
//   hold            : (macro only) job is suspended
module n_way_job_slot
    import n_way_job_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       active,
    input  logic       launch,
    input  logic       kill_phase,
    input  logic       started,
    input  logic       done,
`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
    input  logic       suspend,
    input  logic       resume,
    output logic       hold,
`endif
    output job_state_e state,
    output logic       waiting_nxt,
    output logic       kill
);

    job_state_e state_d;
    logic       live;

    always_comb begin
`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
        live = (state == WAITING) || (state == RUNNING) || (state == SUSPENDED);
`else
        live = (state == WAITING) || (state == RUNNING);
`endif
    end

    always_comb begin
        state_d = state;
        kill    = 1'b0;
        if (launch) begin
            state_d = WAITING;
        end else if (active && live) begin
            // done wins over both started and an in-progress kill
            if (done) begin
                state_d = FINISHED;
            end else if (kill_phase) begin
                state_d = KILLED;
                kill    = 1'b1;
            end else begin
                case (state)
                    WAITING: if (started) state_d = RUNNING;
`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
                    RUNNING:   if (suspend && !resume) state_d = SUSPENDED;
                    SUSPENDED: if (resume && !suspend) state_d = RUNNING;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign waiting_nxt = (state_d == WAITING);

`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
    assign hold = (state == SUSPENDED);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= FINISHED;
        else     state <= state_d;
    end

endmodule

// File: rtl/n_way_job_ctrl.sv
// N-way job controller: launches N_JOBS jobs, waits for all to start,
// awaits one watched job, kills the rest, then signals round completion.
// Optional feature macro: N_WAY_JOB_CTRL_SUSPEND_EN (adds suspend_req,
// resume_req, job_hold).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   go           : start a round (sampled in IDLE only)
//   watch_idx    : job to await, captured on accepted go (out of range -> 0)
//   job_start    : launch pulse per job
//   job_started  : per-job started pulse
//   job_done     : per-job finished pulse
//   job_kill     : kill pulse per job
//   busy         : controller not in IDLE
//   round_done   : end-of-round pulse
//   job_state    : per-job state, slot j at [3j+2:3j]
module n_way_job_ctrl
    import n_way_job_pkg::*;
#(
    parameter  int N_JOBS = 4,
    localparam int IDXW   = ($clog2(N_JOBS) > 1) ? $clog2(N_JOBS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic [IDXW-1:0]               watch_idx,
    output logic [N_JOBS-1:0]             job_start,
    input  logic [N_JOBS-1:0]             job_started,
    input  logic [N_JOBS-1:0]             job_done,
    output logic [N_JOBS-1:0]             job_kill,
    output logic                          busy,
    output logic                          round_done,
    output logic [JOB_STATE_W*N_JOBS-1:0] job_state
`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
    ,
    input  logic [N_JOBS-1:0]             suspend_req,
    input  logic [N_JOBS-1:0]             resume_req,
    output logic [N_JOBS-1:0]             job_hold
`endif
);

    ctrl_state_e       state, state_d;
    logic [IDXW-1:0]   watch_q, watch_d;
    logic              launch, kill_phase, active;
    logic [N_JOBS-1:0] waiting_nxt;
    job_state_e        slot_state [N_JOBS];

    assign watch_d = ({1'b0, watch_idx} < (IDXW+1)'(N_JOBS)) ? watch_idx : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            watch_q <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && go) watch_q <= watch_d;
        end
    end

    always_comb begin
        state_d    = state;
        launch     = 1'b0;
        kill_phase = 1'b0;
        round_done = 1'b0;
        job_start  = '0;
        busy       = (state != IDLE);
        active     = (state != IDLE);
        case (state)
            IDLE:     if (go) state_d = LAUNCH;
            LAUNCH: begin
                launch    = 1'b1;
                job_start = '1;
                state_d   = WAIT_ALL;
            end
            // Uses next-state so WAIT_ALL can exit in its first cycle.
            WAIT_ALL: if (waiting_nxt == '0) state_d = AWAIT;
            AWAIT:    if (slot_state[watch_q] == FINISHED) state_d = KILL;
            KILL: begin
                kill_phase = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                round_done = 1'b1;
                state_d    = IDLE;
            end
            default:  state_d = IDLE;
        endcase
        // Outputs are forced quiet for the whole reset, including the first
        // cycle when the state register may still hold a mid-round value.
        if (rst) begin
            launch     = 1'b0;
            kill_phase = 1'b0;
            round_done = 1'b0;
            job_start  = '0;
            busy       = 1'b0;
            active     = 1'b0;
        end
    end

    for (genvar j = 0; j < N_JOBS; j++) begin : g_slot
        n_way_job_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .active      (active),
            .launch      (launch),
            .kill_phase  (kill_phase),
            .started     (job_started[j]),
            .done        (job_done[j]),
`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
            .suspend     (suspend_req[j]),
            .resume      (resume_req[j]),
            .hold        (job_hold[j]),
`endif
            .state       (slot_state[j]),
            .waiting_nxt (waiting_nxt[j]),
            .kill        (job_kill[j])
        );
        assign job_state[JOB_STATE_W*j +: JOB_STATE_W] = slot_state[j];
    end

endmodule

// File: tb/tb_n_way_job_ctrl.sv
// Self-checking bench for n_way_job_ctrl (N_JOBS=4) plus a 3-job instance
// for out-of-range watch index handling. Expected round outcomes are queued
// when a round is driven and compared when round_done appears.
module tb_n_way_job_ctrl;
    import n_way_job_pkg::*;

    logic        clk;
    logic        rst;
    logic        go;
    logic [1:0]  watch_idx;
    logic [3:0]  job_start, job_started, job_done, job_kill;
    logic        busy, round_done;
    logic [11:0] job_state;
`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
    logic [3:0]  suspend_req, resume_req, job_hold;
`endif

    logic        go3;
    logic [1:0]  watch3;
    logic [2:0]  start3, started3, done3, kill3;
    logic        busy3, rd3;
    logic [8:0]  state3;

    n_way_job_ctrl #(.N_JOBS(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .watch_idx   (watch_idx),
        .job_start   (job_start),
        .job_started (job_started),
        .job_done    (job_done),
        .job_kill    (job_kill),
        .busy        (busy),
        .round_done  (round_done),
        .job_state   (job_state)
`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
        ,
        .suspend_req (suspend_req),
        .resume_req  (resume_req),
        .job_hold    (job_hold)
`endif
    );

    n_way_job_ctrl #(.N_JOBS(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .go          (go3),
        .watch_idx   (watch3),
        .job_start   (start3),
        .job_started (started3),
        .job_done    (done3),
        .job_kill    (kill3),
        .busy        (busy3),
        .round_done  (rd3),
        .job_state   (state3)
`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
        ,
        .suspend_req (3'b000),
        .resume_req  (3'b000),
        .job_hold    ()
`endif
    );

    typedef struct {
        logic [3:0]  kill;
        logic [11:0] states;
        int          lat;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   launch_cyc = 0;
    int   rd_count = 0;
    logic [3:0] prev_kill = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [11:0] st(input job_state_e a3, input job_state_e a2,
                                       input job_state_e a1, input job_state_e a0);
        return {a3, a2, a1, a0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round monitor: kill vector seen in the KILL cycle, states and latency
    // are compared when round_done fires.
    always @(negedge clk) begin
        if (!rst) begin
            if (job_start == 4'hF) launch_cyc = cyc;
            if (round_done) begin
                rd_count++;
                check_eq("sb_has_entry", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("kill_vec", prev_kill, e.kill);
                    check_eq("kill_one_cycle", job_kill, 0);
                    check_eq("final_states", job_state, e.states);
                    check_eq("launch_to_kill", cyc - launch_cyc - 1, e.lat);
                end
            end
        end
        prev_kill = job_kill;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rd_before;
        rst = 1'b1; go = 1'b0; watch_idx = '0; job_started = '0; job_done = '0;
        go3 = 1'b0; watch3 = '0; started3 = '0; done3 = '0;
`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
        suspend_req = '0; resume_req = '0;
`endif
        repeat (3) step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_start", job_start, 0);
        check_eq("rst_kill", job_kill, 0);
        check_eq("rst_round_done", round_done, 0);
        check_eq("rst_states", job_state, 0);
        rst = 1'b0;
        step();
        check_eq("idle_busy", busy, 0);

        // A: staggered starts, watched job 1 finishes late
        sb.push_back('{4'b1101, st(KILLED, KILLED, FINISHED, KILLED), 9});
        go = 1'b1; watch_idx = 2'd1; step(); go = 1'b0;
        check_eq("launch_busy", busy, 1);
        check_eq("launch_start", job_start, 4'hF);
        step();
        check_eq("launch_waiting", job_state, st(WAITING, WAITING, WAITING, WAITING));
        job_started = 4'b0001; step();
        job_started = 4'b0010; step();
        job_started = 4'b0100; step();
        job_started = 4'b1000; step();
        job_started = 4'b0000;
        check_eq("all_running", job_state, st(RUNNING, RUNNING, RUNNING, RUNNING));
        step(); step();
        job_done = 4'b0010; step(); job_done = '0;
        step(); step(); step();
        check_eq("a_idle", busy, 0);

        // B: watched job started+done in WAIT_ALL, job 0 starts late
        sb.push_back('{4'b1011, st(KILLED, FINISHED, KILLED, KILLED), 6});
        go = 1'b1; watch_idx = 2'd2; step(); go = 1'b0; step();
        job_started = 4'b1110; job_done = 4'b0100; step();
        job_started = '0; job_done = '0;
        step(); step();
        check_eq("b_job0_waiting", job_state[2:0], WAITING);
        job_started = 4'b0001; step(); job_started = '0;
        step(); step(); step();

        // C: minimum latency; job 3 finishes in the KILL cycle
        sb.push_back('{4'b0110, st(FINISHED, KILLED, KILLED, FINISHED), 3});
        go = 1'b1; watch_idx = 2'd0; step(); go = 1'b0; step();
        job_started = 4'b1111; job_done = 4'b0001; step();
        job_started = '0; job_done = '0;
        step();
        job_done = 4'b1000; step(); job_done = '0;
        step();

        // D: go during AWAIT is ignored
        sb.push_back('{4'b0111, st(FINISHED, KILLED, KILLED, KILLED), 5});
        go = 1'b1; watch_idx = 2'd3; step(); go = 1'b0; step();
        job_started = 4'b1111; step(); job_started = '0;
        go = 1'b1; watch_idx = 2'd0; step(); go = 1'b0;
        job_done = 4'b1000; step(); job_done = '0;
        step(); step(); step(); step();
        check_eq("d_go_ignored", busy, 0);

        // E: reset in AWAIT aborts silently
        rd_before = rd_count;
        go = 1'b1; watch_idx = 2'd0; step(); go = 1'b0; step();
        job_started = 4'b1111; step(); job_started = '0;
        rst = 1'b1; #1;
        check_eq("e_rst_busy", busy, 0);
        check_eq("e_rst_kill", job_kill, 0);
        step(); rst = 1'b0;
        check_eq("e_states", job_state, 0);
        check_eq("e_busy", busy, 0);
        repeat (3) step();
        check_eq("e_no_round_done", rd_count, rd_before);

`ifdef N_WAY_JOB_CTRL_SUSPEND_EN
        // F: suspended job held until KILL, then killed
        sb.push_back('{4'b1101, st(KILLED, KILLED, FINISHED, KILLED), 5});
        go = 1'b1; watch_idx = 2'd1; step(); go = 1'b0; step();
        job_started = 4'b1111; step(); job_started = '0;
        suspend_req = 4'b0001; step(); suspend_req = '0;
        check_eq("f_hold_c3", job_hold, 4'b0001);
        suspend_req = 4'b0100; resume_req = 4'b0100; job_done = 4'b0010; step();
        suspend_req = '0; resume_req = '0; job_done = '0;
        check_eq("f_hold_c4", job_hold, 4'b0001);
        step();
        check_eq("f_hold_kill", job_hold, 4'b0001);
        step();
        check_eq("f_hold_done", job_hold, 4'b0000);
        step();
`endif

        // 3-job instance: watch index 3 is out of range and must act as 0
        go3 = 1'b1; watch3 = 2'd3; step(); go3 = 1'b0; step();
        started3 = 3'b111; step(); started3 = '0;
        done3 = 3'b010; step(); done3 = '0;
        step();
        done3 = 3'b001; step(); done3 = '0;
        step(); step(); step(); step();
        check_eq("w3_states", state3, {KILLED, FINISHED, FINISHED});
        check_eq("w3_idle", busy3, 0);

        check_eq("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
